lns_mac_ctrl: RTL



---
 rtl/lns_mac_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lns_mac_ctrl.sv
// LNS dot-product sequencer: forms log-domain products of streamed operand pairs and
// accumulates them through one shared external LNS adder, reporting sum and term count.
module lns_mac_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_a,
    input  logic [11:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [11:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic [11:0]      add_x,
    output logic [11:0]      add_y,
    input  logic [11:0]      add_out
);

    localparam logic [11:0]        LnsZero = 12'h400;
    localparam logic [10:0]        MagZero = 11'h400;
    localparam logic [10:0]        MagSat  = 11'h3FF;
    localparam logic signed [11:0] MagMax  = 12'sd1023;
    localparam logic signed [11:0] MagMin  = -12'sd1023;

    localparam logic [0:0] StRun  = 1'b0;
    localparam logic [0:0] StDone = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             p_valid_q, p_valid_d;
    logic             p_last_q, p_last_d;
    logic [11:0]      p_reg_q, p_reg_d;
    logic [11:0]      acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [11:0]      out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;

    logic        accept;
    logic        consume;
    logic        prod_sign;
    logic [11:0] prod_sum;
    logic [11:0] prod;

    // Log-domain multiply: add sign-extended log magnitudes, saturate high, flush low to zero.
    always_comb begin
        prod_sign = in_a[11] ^ in_b[11];
        prod_sum  = {in_a[10], in_a[10:0]} + {in_b[10], in_b[10:0]};
        if ((in_a[10:0] == MagZero) || (in_b[10:0] == MagZero)) begin
            prod = LnsZero;
        end else if ($signed(prod_sum) > MagMax) begin
            prod = {prod_sign, MagSat};
        end else if ($signed(prod_sum) < MagMin) begin
            prod = LnsZero;
        end else begin
            prod = {prod_sign, prod_sum[10:0]};
        end
    end

    assign in_ready  = (state_q == StRun) && !(p_valid_q && p_last_q);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;
    assign consume   = p_valid_q && (state_q == StRun);

    assign add_x     = acc_q;
    assign add_y     = p_reg_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

    always_comb begin
        state_d     = state_q;
        p_valid_d   = p_valid_q;
        p_last_d    = p_last_q;
        p_reg_d     = p_reg_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;

        if (accept) begin
            p_valid_d = 1'b1;
            p_last_d  = in_last;
            p_reg_d   = prod;
        end else if (consume) begin
            p_valid_d = 1'b0;
        end

        if (consume) begin
            // Zero operands skip the adder so its result is never relied on for them.
            if (acc_q[10:0] == MagZero) begin
                acc_d = p_reg_q;
            end else if (p_reg_q[10:0] == MagZero) begin
                acc_d = acc_q;
            end else begin
                acc_d = add_out;
            end
            count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
            if (p_last_q) begin
                state_d     = StDone;
                out_sum_d   = acc_d;
                out_count_d = count_d;
            end
        end else if ((state_q == StDone) && out_ready) begin
            acc_d   = LnsZero;
            count_d = '0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_reg_q     <= LnsZero;
            acc_q       <= LnsZero;
            count_q     <= '0;
            out_sum_q   <= LnsZero;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            p_reg_q     <= p_reg_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

endmodule
